// File: rtl/highway_way.sv
// Highway-side traffic light controller: green by default, yields to the country
// road on request, waits for it to take and return the right of way, then clears.
//
// state    | meaning
// GREEN    | highway green, counting minimum green time
// YELLOW   | highway yellow
// RED_WAIT | highway red, waiting for country side to leave red
// RED_HOLD | country side owns the road (or a conflict was seen)
// ALL_RED  | clearance after country side returns to red
module highway_way #(
    parameter int unsigned CLEAR_CYC  = 2,
    parameter int unsigned GRANT_WAIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_c,
    input  logic [6:0] Timeout_h,
    input  logic [3:0] timeout_h,
    input  logic [2:0] out_c,
    output logic [2:0] out_h,
    output logic       req_pending,
    output logic       conflict
);

    typedef enum logic [2:0] {
        GREEN    = 3'd0,
        YELLOW   = 3'd1,
        RED_WAIT = 3'd2,
        RED_HOLD = 3'd3,
        ALL_RED  = 3'd4
    } state_t;

    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_RED    = 3'b100;

    localparam logic [6:0] GRANT_LAST = 7'(GRANT_WAIT - 1);
    localparam logic [6:0] CLEAR_LAST = 7'(CLEAR_CYC - 1);

    state_t     state;
    state_t     state_nxt;
    logic [6:0] count;
    logic [6:0] count_nxt;
    logic       req_nxt;
    logic       conflict_nxt;
    logic       release_grant;
    logic       req_clear;
    logic       country_red;

    assign country_red = (out_c == LIGHT_RED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= GREEN;
            count       <= '0;
            req_pending <= 1'b0;
            conflict    <= 1'b0;
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            req_pending <= req_nxt;
            conflict    <= conflict_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        conflict_nxt  = 1'b0;
        release_grant = 1'b0;
        case (state)
            GREEN: begin
                if (!country_red) begin
                    state_nxt    = RED_HOLD;
                    conflict_nxt = 1'b1;
                end else if ((count >= Timeout_h) && (req_pending || sensor_c)) begin
                    state_nxt = YELLOW;
                end else if (count < Timeout_h) begin
                    count_nxt = count + 7'd1;
                end
            end
            YELLOW: begin
                if (!country_red) begin
                    state_nxt    = RED_HOLD;
                    conflict_nxt = 1'b1;
                end else if (count < {3'b000, timeout_h}) begin
                    count_nxt = count + 7'd1;
                end else begin
                    state_nxt = RED_WAIT;
                end
            end
            RED_WAIT: begin
                if (!country_red) begin
                    state_nxt = RED_HOLD;
                end else if (count >= GRANT_LAST) begin
                    state_nxt     = GREEN;
                    release_grant = 1'b1;
                end else begin
                    count_nxt = count + 7'd1;
                end
            end
            RED_HOLD: begin
                if (country_red) state_nxt = ALL_RED;
            end
            ALL_RED: begin
                if (count >= CLEAR_LAST) state_nxt = GREEN;
                else                     count_nxt = count + 7'd1;
            end
            default: state_nxt = GREEN;
        endcase

        if (state_nxt != state) count_nxt = '0;

        // Clearing beats a simultaneous sensor hit
        req_clear = ((state_nxt == RED_HOLD) && (state != RED_HOLD)) || release_grant;
        req_nxt   = req_clear ? 1'b0 : (req_pending | sensor_c);
    end

    always_comb begin
        case (state)
            GREEN:   out_h = LIGHT_GREEN;
            YELLOW:  out_h = LIGHT_YELLOW;
            default: out_h = LIGHT_RED;
        endcase
    end

endmodule

// File: tb/tb_highway_way.sv
// Self-checking bench for highway_way: scripted stimulus per scenario with a
// queue of expected {out_h, req_pending, conflict} popped one cycle later.
module tb_highway_way;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sensor_c = 1'b0;
    logic [6:0] Timeout_h = 7'd5;
    logic [3:0] timeout_h = 4'd2;
    logic [2:0] out_c = 3'b100;
    logic [2:0] out_h;
    logic       req_pending;
    logic       conflict;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];

    highway_way #(.CLEAR_CYC(2), .GRANT_WAIT(4)) dut (
        .clk(clk),
        .reset(reset),
        .sensor_c(sensor_c),
        .Timeout_h(Timeout_h),
        .timeout_h(timeout_h),
        .out_c(out_c),
        .out_h(out_h),
        .req_pending(req_pending),
        .conflict(conflict)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1;
        sensor_c = 1'b0;
        out_c = 3'b100;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [4:0] e;
        reset = 1'b1;
        sensor_c = 1'b1;
        out_c = 3'b001;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(5'b001_0_0);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({out_h, req_pending, conflict} !== e) begin
                errors++;
                $display("FAIL reset step %0d: got %b_%b_%b expected %b_%b_%b", i,
                         out_h, req_pending, conflict, e[4:2], e[1], e[0]);
            end
        end
        reset = 1'b0;
        sensor_c = 1'b0;
        out_c = 3'b100;
    endtask

    task automatic test_idle_green();
        logic [4:0] e;
        Timeout_h = 7'd5;
        timeout_h = 4'd2;
        do_reset();
        for (int i = 0; i < 51; i++) begin
            // Count must be saturated: one sensor cycle goes straight to yellow
            sensor_c = (i == 50);
            exp_q.push_back((i == 50) ? 5'b010_1_0 : 5'b001_0_0);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({out_h, req_pending, conflict} !== e) begin
                errors++;
                $display("FAIL idle_green step %0d: got %b_%b_%b expected %b_%b_%b", i,
                         out_h, req_pending, conflict, e[4:2], e[1], e[0]);
            end
        end
    endtask

    // Entries: {sensor_c, out_c, exp out_h, exp req_pending, exp conflict}
    task automatic test_full_cycle();
        logic [8:0] t[16];
        logic [4:0] e;
        t = '{9'b1_100_001_1_0, 9'b1_100_001_1_0, 9'b1_100_001_1_0, 9'b1_100_001_1_0,
              9'b1_100_001_1_0, 9'b1_100_010_1_0, 9'b1_100_010_1_0, 9'b1_100_010_1_0,
              9'b1_100_100_1_0, 9'b1_001_100_0_0, 9'b0_001_100_0_0, 9'b0_001_100_0_0,
              9'b0_010_100_0_0, 9'b0_100_100_0_0, 9'b0_100_100_0_0, 9'b0_100_001_0_0};
        Timeout_h = 7'd5;
        timeout_h = 4'd2;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            sensor_c = t[i][8];
            out_c = t[i][7:5];
            exp_q.push_back(t[i][4:0]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({out_h, req_pending, conflict} !== e) begin
                errors++;
                $display("FAIL full_cycle step %0d: got %b_%b_%b expected %b_%b_%b", i,
                         out_h, req_pending, conflict, e[4:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_missed_grant();
        logic [8:0] t[11];
        logic [4:0] e;
        t = '{9'b1_100_001_1_0, 9'b0_100_001_1_0, 9'b0_100_010_1_0, 9'b0_100_010_1_0,
              9'b0_100_100_1_0, 9'b0_100_100_1_0, 9'b0_100_100_1_0, 9'b0_100_100_1_0,
              9'b0_100_001_0_0, 9'b0_100_001_0_0, 9'b0_100_001_0_0};
        Timeout_h = 7'd2;
        timeout_h = 4'd1;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            sensor_c = t[i][8];
            out_c = t[i][7:5];
            exp_q.push_back(t[i][4:0]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({out_h, req_pending, conflict} !== e) begin
                errors++;
                $display("FAIL missed_grant step %0d: got %b_%b_%b expected %b_%b_%b", i,
                         out_h, req_pending, conflict, e[4:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_conflict();
        logic [8:0] t[7];
        logic [4:0] e;
        t = '{9'b0_100_001_0_0, 9'b1_100_001_1_0, 9'b0_001_100_0_1, 9'b0_001_100_0_0,
              9'b0_100_100_0_0, 9'b0_100_100_0_0, 9'b0_100_001_0_0};
        Timeout_h = 7'd5;
        timeout_h = 4'd2;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            sensor_c = t[i][8];
            out_c = t[i][7:5];
            exp_q.push_back(t[i][4:0]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({out_h, req_pending, conflict} !== e) begin
                errors++;
                $display("FAIL conflict step %0d: got %b_%b_%b expected %b_%b_%b", i,
                         out_h, req_pending, conflict, e[4:2], e[1], e[0]);
            end
        end
    endtask

    // Entries: {reset, sensor_c, out_c, exp out_h, exp req_pending, exp conflict}
    task automatic test_reset_mid_yellow();
        logic [9:0] t[6];
        logic [4:0] e;
        t = '{10'b0_1_100_001_1_0, 10'b0_1_100_010_1_0, 10'b0_1_100_010_1_0,
              10'b1_1_001_001_0_0, 10'b0_1_100_001_1_0, 10'b0_1_100_010_1_0};
        Timeout_h = 7'd1;
        timeout_h = 4'd3;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            reset = t[i][9];
            sensor_c = t[i][8];
            out_c = t[i][7:5];
            exp_q.push_back(t[i][4:0]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({out_h, req_pending, conflict} !== e) begin
                errors++;
                $display("FAIL reset_mid_yellow step %0d: got %b_%b_%b expected %b_%b_%b", i,
                         out_h, req_pending, conflict, e[4:2], e[1], e[0]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_zero_timeouts();
        logic [8:0] t[7];
        logic [4:0] e;
        t = '{9'b1_100_010_1_0, 9'b1_100_100_1_0, 9'b1_100_100_1_0, 9'b1_100_100_1_0,
              9'b1_100_100_1_0, 9'b1_100_001_0_0, 9'b1_100_010_1_0};
        Timeout_h = 7'd0;
        timeout_h = 4'd0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            sensor_c = t[i][8];
            out_c = t[i][7:5];
            exp_q.push_back(t[i][4:0]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({out_h, req_pending, conflict} !== e) begin
                errors++;
                $display("FAIL zero_timeouts step %0d: got %b_%b_%b expected %b_%b_%b", i,
                         out_h, req_pending, conflict, e[4:2], e[1], e[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_green();
        test_full_cycle();
        test_missed_grant();
        test_conflict();
        test_reset_mid_yellow();
        test_zero_timeouts();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
